// File: rtl/muldiv_pkg.sv
// ---------------------------------------------------------------------------
// muldiv_pkg : shared RV32M encodings and divider state type
// Revision   : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package muldiv_pkg;

  localparam logic [6:0] OPCODE_R      = 7'b0110011;
  localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

  localparam logic [2:0] FUNCT3_DIV  = 3'b100;
  localparam logic [2:0] FUNCT3_DIVU = 3'b101;
  localparam logic [2:0] FUNCT3_REM  = 3'b110;
  localparam logic [2:0] FUNCT3_REMU = 3'b111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } div_state_t;

endpackage

`default_nettype wire

// File: rtl/div_iter_step.sv
// ---------------------------------------------------------------------------
// div_iter_step : one combinational radix-2 restoring division step
// Revision      : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module div_iter_step #(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] rem,
  input  logic [XLEN-1:0] quo,
  input  logic [XLEN-1:0] dvsr,
  output logic [XLEN-1:0] rem_next,
  output logic [XLEN-1:0] quo_next
);

  logic [XLEN:0] rem_sh;
  logic [XLEN:0] trial;

  // One extra bit so the trial subtraction's sign is a clean borrow flag.
  assign rem_sh   = {rem, quo[XLEN-1]};
  assign trial    = rem_sh - {1'b0, dvsr};
  assign rem_next = trial[XLEN] ? rem_sh[XLEN-1:0] : trial[XLEN-1:0];
  assign quo_next = {quo[XLEN-2:0], ~trial[XLEN]};

endmodule

`default_nettype wire

// File: rtl/div_unit_seq.sv
// ---------------------------------------------------------------------------
// div_unit_seq : multi-cycle restoring divider for DIV/DIVU/REM/REMU
// Revision     : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module div_unit_seq
  import muldiv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            start_i,
  input  logic [2:0]      funct3_i,
  input  logic [XLEN-1:0] dividend_i,
  input  logic [XLEN-1:0] divisor_i,
  input  logic            flush_i,
  output logic            busy_o,
  output logic            valid_o,
  output logic [XLEN-1:0] result_o
);

  localparam int CNT_W = $clog2(XLEN);
  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  div_state_t state, state_next;

  logic [XLEN-1:0] rem, quo, dvsr;
  logic [XLEN-1:0] rem_next, quo_next;
  logic [CNT_W-1:0] cnt;
  logic             op_rem;
  logic             neg_q, neg_r;

  logic            accept, is_signed, a_neg, b_neg, div0, ovf, special;
  logic [XLEN-1:0] a_mag, b_mag, special_res, q_fix, r_fix;
  logic            unused_f3;

  assign unused_f3 = funct3_i[2];

  assign is_signed = ~funct3_i[0];
  assign a_neg     = is_signed & dividend_i[XLEN-1];
  assign b_neg     = is_signed & divisor_i[XLEN-1];
  assign a_mag     = a_neg ? -dividend_i : dividend_i;
  assign b_mag     = b_neg ? -divisor_i  : divisor_i;
  assign div0      = (divisor_i == '0);
  assign ovf       = is_signed & (dividend_i == MIN_NEG) & (divisor_i == '1);
  assign special   = div0 | ovf;

  // Division by zero wins over overflow; both bypass the iteration entirely.
  always_comb begin
    special_res = '0;
    if (div0)
      special_res = funct3_i[1] ? dividend_i : '1;
    else if (ovf)
      special_res = funct3_i[1] ? '0 : MIN_NEG;
  end

  assign accept = start_i & ~flush_i & (state != CALC);

  div_iter_step #(.XLEN(XLEN)) u_step (
    .rem      (rem),
    .quo      (quo),
    .dvsr     (dvsr),
    .rem_next (rem_next),
    .quo_next (quo_next)
  );

  assign q_fix = neg_q ? -quo_next : quo_next;
  assign r_fix = neg_r ? -rem_next : rem_next;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state <= IDLE;
    else         state <= state_next;
  end

  always_comb begin
    state_next = state;
    if (flush_i) begin
      state_next = IDLE;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (accept) state_next = special ? DONE : CALC;
          else        state_next = IDLE;
        end
        CALC:    if (cnt == '0) state_next = DONE;
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rem      <= '0;
      quo      <= '0;
      dvsr     <= '0;
      cnt      <= '0;
      op_rem   <= 1'b0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      result_o <= '0;
    end else if (accept) begin
      op_rem <= funct3_i[1];
      if (special) begin
        result_o <= special_res;
      end else begin
        rem   <= '0;
        quo   <= a_mag;
        dvsr  <= b_mag;
        cnt   <= CNT_W'(XLEN-1);
        neg_q <= a_neg ^ b_neg;
        neg_r <= a_neg;
      end
    end else if (state == CALC && !flush_i) begin
      rem <= rem_next;
      quo <= quo_next;
      cnt <= cnt - 1'b1;
      if (cnt == '0)
        result_o <= op_rem ? r_fix : q_fix;
    end
  end

  assign busy_o  = (state == CALC);
  assign valid_o = (state == DONE);

endmodule

`default_nettype wire

// File: tb/tb_div_unit_seq.sv
// ---------------------------------------------------------------------------
// tb_div_unit_seq : directed + random checks of div_unit_seq against a model
// Revision        : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_div_unit_seq;

  localparam int XLEN = 32;

  logic            clk_i = 1'b0;
  logic            rst_ni;
  logic            start_i;
  logic [2:0]      funct3_i;
  logic [XLEN-1:0] dividend_i;
  logic [XLEN-1:0] divisor_i;
  logic            flush_i;
  logic            busy_o;
  logic            valid_o;
  logic [XLEN-1:0] result_o;

  int n_checks = 0;
  int n_pass   = 0;

  div_unit_seq #(.XLEN(XLEN)) dut (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .start_i    (start_i),
    .funct3_i   (funct3_i),
    .dividend_i (dividend_i),
    .divisor_i  (divisor_i),
    .flush_i    (flush_i),
    .busy_o     (busy_o),
    .valid_o    (valid_o),
    .result_o   (result_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [XLEN-1:0] obs, input logic [XLEN-1:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
  endtask

  // RISC-V M semantics from plain integer arithmetic.
  function automatic logic [XLEN-1:0] model(input logic [2:0] f3, input logic [XLEN-1:0] a,
                                            input logic [XLEN-1:0] b);
    longint sa, sb;
    if (b == 0) return f3[1] ? a : '1;
    if (f3[0]) return f3[1] ? (a % b) : (a / b);
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    return f3[1] ? XLEN'(sa % sb) : XLEN'(sa / sb);
  endfunction

  function automatic int model_lat(input logic [2:0] f3, input logic [XLEN-1:0] a,
                                   input logic [XLEN-1:0] b);
    if (b == 0) return 1;
    if (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
    return XLEN + 1;
  endfunction

  // Issue at the current sample point; returns at the valid_o sample (DONE cycle).
  // With mid_start set, a conflicting start is pulsed during CALC.
  task automatic run_op(input string tag, input logic [2:0] f3, input logic [XLEN-1:0] a,
                        input logic [XLEN-1:0] b, input bit mid_start);
    int lat, busy_cnt;
    logic [XLEN-1:0] exp_r;
    exp_r = model(f3, a, b);
    start_i = 1'b1; funct3_i = f3; dividend_i = a; divisor_i = b;
    @(posedge clk_i); #1;
    start_i = 1'b0; dividend_i = $urandom; divisor_i = $urandom;
    lat = 1; busy_cnt = 0;
    while (!valid_o && lat < 100) begin
      if (busy_o) busy_cnt++;
      if (mid_start && lat == 5) begin
        start_i = 1'b1; funct3_i = 3'b111; divisor_i = 0;
      end else begin
        start_i = 1'b0;
      end
      @(posedge clk_i); #1;
      lat++;
    end
    start_i = 1'b0;
    check({tag, " latency"}, XLEN'(lat), XLEN'(model_lat(f3, a, b)));
    check({tag, " busy cycles"}, XLEN'(busy_cnt), XLEN'(model_lat(f3, a, b) - 1));
    check({tag, " result"}, result_o, exp_r);
  endtask

  task automatic idle_cycle();
    @(posedge clk_i); #1;
  endtask

  initial begin
    logic [XLEN-1:0] held;
    logic [2:0]      rf3;
    logic [XLEN-1:0] ra, rb;
    bit              saw_valid;

    rst_ni = 1'b0; start_i = 1'b0; flush_i = 1'b0;
    funct3_i = 3'b100; dividend_i = '0; divisor_i = '0;
    repeat (3) @(posedge clk_i);
    #1;
    check("reset busy",   XLEN'(busy_o),  '0);
    check("reset valid",  XLEN'(valid_o), '0);
    check("reset result", result_o,       '0);
    @(negedge clk_i); rst_ni = 1'b1;
    @(posedge clk_i); #1;

    run_op("divu 100/7", 3'b101, 100, 7, 0);
    idle_cycle();
    check("valid one-cycle pulse", XLEN'(valid_o), '0);
    run_op("remu 100/7", 3'b111, 100, 7, 0);
    run_op("div -20/3",  3'b100, 32'hFFFF_FFEC, 3, 0);
    run_op("rem -20/3",  3'b110, 32'hFFFF_FFEC, 3, 0);
    run_op("rem 20/-3",  3'b110, 20, 32'hFFFF_FFFD, 0);
    run_op("div 5/0",    3'b100, 5, 0, 0);
    run_op("remu 5/0",   3'b111, 5, 0, 0);
    run_op("div ovf",    3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    run_op("rem ovf",    3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    run_op("divu min/-1 unsigned", 3'b101, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    idle_cycle();
    run_op("divu start ignored in calc", 3'b101, 100, 7, 1);
    idle_cycle();

    // Flush on CALC cycle 10, with a start that must be dropped.
    held = result_o;
    start_i = 1'b1; funct3_i = 3'b101; dividend_i = 1000; divisor_i = 10;
    @(posedge clk_i); #1;
    start_i = 1'b0;
    repeat (9) idle_cycle();
    check("busy before flush", XLEN'(busy_o), 1);
    flush_i = 1'b1; start_i = 1'b1; funct3_i = 3'b111; divisor_i = 0;
    @(posedge clk_i); #1;
    flush_i = 1'b0; start_i = 1'b0;
    check("flush busy",   XLEN'(busy_o),  '0);
    check("flush valid",  XLEN'(valid_o), '0);
    check("flush result", result_o,       held);
    saw_valid = 1'b0;
    repeat (40) begin
      if (valid_o || busy_o) saw_valid = 1'b1;
      idle_cycle();
    end
    check("no activity after flush", XLEN'(saw_valid), '0);
    run_op("divu 9/2 after flush", 3'b101, 9, 2, 0);
    idle_cycle();

    // Async reset mid-CALC.
    run_op("divu 77/7 pre-reset", 3'b101, 77, 7, 0);
    start_i = 1'b1; funct3_i = 3'b101; dividend_i = 500; divisor_i = 3;
    @(posedge clk_i); #1;
    start_i = 1'b0;
    repeat (5) idle_cycle();
    #2 rst_ni = 1'b0;
    #1;
    check("async rst busy",   XLEN'(busy_o),  '0);
    check("async rst valid",  XLEN'(valid_o), '0);
    check("async rst result", result_o,       '0);
    @(negedge clk_i); rst_ni = 1'b1;
    saw_valid = 1'b0;
    repeat (40) begin
      @(posedge clk_i); #1;
      if (valid_o) saw_valid = 1'b1;
    end
    check("no valid after reset", XLEN'(saw_valid), '0);

    // Back-to-back: second start issued in the DONE cycle of the first.
    run_op("divu ffffffff/1", 3'b101, 32'hFFFF_FFFF, 1, 0);
    run_op("remu 7/3 back-to-back", 3'b111, 7, 3, 0);
    idle_cycle();

    for (int i = 0; i < 40; i++) begin
      rf3 = 3'(4 + $urandom_range(0, 3));
      case ($urandom_range(0, 5))
        0:       begin ra = $urandom; rb = 0; end
        1:       begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
        2:       begin ra = $urandom; rb = $urandom_range(1, 17); end
        3:       begin ra = $urandom_range(0, 1000); rb = $urandom; end
        default: begin ra = $urandom; rb = $urandom; end
      endcase
      run_op($sformatf("rand%0d f3=%0d", i, rf3), rf3, ra, rb, 0);
      repeat ($urandom_range(0, 2)) idle_cycle();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
